// File: rtl/port_strobed_input.sv
// Strobed-input handshake stage for one 8255A port (A or B).
// Latches peripheral data on STB_n and drives IBF, INTR, INTE and a saturating overrun count.
module port_strobed_input #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int OVR_W       = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Mode1En,
    input  logic             STB_n,
    input  logic [WIDTH-1:0] Pin,
    input  logic             RdBuf,
    input  logic             InteWr,
    input  logic             InteVal,
    output logic [WIDTH-1:0] PInBuf,
    output logic             IBF,
    output logic             INTR,
    output logic             INTE,
    output logic [OVR_W-1:0] OvrCnt,
    output logic             Overrun
);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        STROBED = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t state;
    state_t stateNext;

    logic [SYNC_STAGES-1:0] stbSync;
    logic [SYNC_STAGES-1:0] realSync;
    logic [WIDTH-1:0]       pinSync [SYNC_STAGES];
    logic                   stbPrev;
    logic                   armed;

    logic                   stbS;
    logic                   realS;
    logic [WIDTH-1:0]       pinS;
    logic                   fall;
    logic                   rise;

    logic                   capture;
    logic                   inteNext;
    logic [OVR_W-1:0]       ovrNext;

    assign stbS  = stbSync[SYNC_STAGES-1];
    assign realS = realSync[SYNC_STAGES-1];
    assign pinS  = pinSync[SYNC_STAGES-1];

    // A strobe held low across reset must not look like a fresh fall, so falls
    // only count once a genuine post-reset high level has reached the detector.
    assign fall = armed & stbPrev & ~stbS;
    assign rise = ~stbPrev & stbS;

    always_comb begin
        stateNext = state;
        capture   = 1'b0;
        ovrNext   = OvrCnt;
        inteNext  = InteWr ? InteVal : INTE;

        if (!Mode1En) begin
            stateNext = EMPTY;
            ovrNext   = '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (fall) begin
                        capture   = 1'b1;
                        stateNext = STROBED;
                    end
                end
                STROBED: begin
                    if (fall) begin
                        capture   = 1'b1;
                        stateNext = STROBED;
                    end else if (RdBuf) begin
                        stateNext = EMPTY;
                    end else if (rise) begin
                        stateNext = FULL;
                    end
                end
                FULL: begin
                    if (fall) begin
                        capture   = 1'b1;
                        stateNext = STROBED;
                    end else if (RdBuf) begin
                        stateNext = EMPTY;
                    end
                end
                default: begin
                    stateNext = EMPTY;
                end
            endcase

            // A read always clears the count, even when a capture lands on the same edge.
            if (RdBuf) begin
                ovrNext = '0;
            end else if (fall && (state != EMPTY) && (OvrCnt != '1)) begin
                ovrNext = OvrCnt + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            stbSync  <= '1;
            realSync <= '0;
            stbPrev  <= 1'b1;
            armed    <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                pinSync[i] <= '0;
            end
            state    <= EMPTY;
            PInBuf   <= '0;
            IBF      <= 1'b0;
            INTR     <= 1'b0;
            INTE     <= 1'b0;
            OvrCnt   <= '0;
            Overrun  <= 1'b0;
        end else begin
            stbSync  <= {stbSync[SYNC_STAGES-2:0], STB_n};
            realSync <= {realSync[SYNC_STAGES-2:0], 1'b1};
            for (int i = SYNC_STAGES - 1; i > 0; i--) begin
                pinSync[i] <= pinSync[i-1];
            end
            pinSync[0] <= Pin;
            stbPrev    <= stbS;
            armed      <= armed | (realS & stbS);

            state   <= stateNext;
            INTE    <= inteNext;
            OvrCnt  <= ovrNext;
            Overrun <= (ovrNext != '0);
            IBF     <= (stateNext != EMPTY);
            INTR    <= (stateNext == FULL) & inteNext;

            if (!Mode1En || capture) begin
                PInBuf <= pinS;
            end
        end
    end

endmodule

// File: tb/tb_port_strobed_input.sv
// Randomized scoreboard bench for port_strobed_input, checked against a
// transaction-level model of the strobe handshake.
module tb_port_strobed_input;

    localparam int WIDTH       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int OVR_W       = 4;
    localparam int OVR_MAX     = (1 << OVR_W) - 1;

    logic             Clk = 1'b0;
    logic             Rst = 1'b1;
    logic             Mode1En = 1'b1;
    logic             STB_n = 1'b1;
    logic [WIDTH-1:0] Pin = '0;
    logic             RdBuf = 1'b0;
    logic             InteWr = 1'b0;
    logic             InteVal = 1'b0;
    logic [WIDTH-1:0] PInBuf;
    logic             IBF;
    logic             INTR;
    logic             INTE;
    logic [OVR_W-1:0] OvrCnt;
    logic             Overrun;

    always #5 Clk = ~Clk;

    port_strobed_input #(
        .WIDTH(WIDTH),
        .SYNC_STAGES(SYNC_STAGES),
        .OVR_W(OVR_W)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .Mode1En(Mode1En),
        .STB_n(STB_n),
        .Pin(Pin),
        .RdBuf(RdBuf),
        .InteWr(InteWr),
        .InteVal(InteVal),
        .PInBuf(PInBuf),
        .IBF(IBF),
        .INTR(INTR),
        .INTE(INTE),
        .OvrCnt(OvrCnt),
        .Overrun(Overrun)
    );

    typedef struct packed {
        logic [WIDTH-1:0] pinBuf;
        logic             ibf;
        logic             intr;
        logic             inte;
        logic [OVR_W-1:0] ovrCnt;
        logic             overrun;
    } exp_t;

    exp_t expQ[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Model state: pin/strobe history as seen by the CPU side, plus the handshake facts.
    logic             stbQ[$];
    bit               realQ[$];
    logic [WIDTH-1:0] pinQ[$];
    bit               mArmed;
    bit               mHasData;
    bit               mReleased;
    bit               mInte;
    int               mOvr;
    logic [WIDTH-1:0] mBuf;
    bit               modeSel = 1'b1;

    task automatic modelFlushHistory();
        stbQ.delete();
        realQ.delete();
        pinQ.delete();
        for (int i = 0; i <= SYNC_STAGES; i++) begin
            stbQ.push_back(1'b1);
            realQ.push_back(1'b0);
            pinQ.push_back('0);
        end
    endtask

    task automatic modelStep(input logic rst, input logic mode, input logic stb,
                             input logic [WIDTH-1:0] pin, input logic rd,
                             input logic iw, input logic iv);
        bit   fall;
        bit   rise;
        exp_t e;
        if (rst) begin
            mArmed = 0; mHasData = 0; mReleased = 0; mInte = 0; mOvr = 0; mBuf = '0;
            modelFlushHistory();
        end else begin
            fall = mArmed && stbQ[0] && !stbQ[1];
            rise = !stbQ[0] && stbQ[1];
            if (realQ[1] && stbQ[1]) mArmed = 1;
            if (iw) mInte = iv;
            if (!mode) begin
                mHasData = 0; mReleased = 0; mOvr = 0; mBuf = pinQ[1];
            end else begin
                if (fall) begin
                    if (mHasData && !rd && mOvr < OVR_MAX) mOvr++;
                    mBuf = pinQ[1]; mHasData = 1; mReleased = 0;
                end else if (rd && mHasData) begin
                    mHasData = 0; mReleased = 0;
                end else if (rise && mHasData) begin
                    mReleased = 1;
                end
                if (rd) mOvr = 0;
            end
            void'(stbQ.pop_front());
            void'(realQ.pop_front());
            void'(pinQ.pop_front());
            stbQ.push_back(stb);
            realQ.push_back(1'b1);
            pinQ.push_back(pin);
        end
        e.pinBuf  = mBuf;
        e.ibf     = mHasData;
        e.intr    = mHasData && mReleased && mInte;
        e.inte    = mInte;
        e.ovrCnt  = OVR_W'(mOvr);
        e.overrun = (mOvr != 0);
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic rst, input logic stb, input logic [WIDTH-1:0] pin,
                                 input logic rd = 1'b0, input logic iw = 1'b0,
                                 input logic iv = 1'b0);
        Rst = rst; Mode1En = modeSel; STB_n = stb; Pin = pin;
        RdBuf = rd; InteWr = iw; InteVal = iv;
        @(posedge Clk);
        #1;
        modelStep(rst, modeSel, stb, pin, rd, iw, iv);
    endtask

    task automatic cmp(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        cmp("PInBuf",  PInBuf,           e.pinBuf);
        cmp("IBF",     WIDTH'(IBF),      WIDTH'(e.ibf));
        cmp("INTR",    WIDTH'(INTR),     WIDTH'(e.intr));
        cmp("INTE",    WIDTH'(INTE),     WIDTH'(e.inte));
        cmp("OvrCnt",  WIDTH'(OvrCnt),   WIDTH'(e.ovrCnt));
        cmp("Overrun", WIDTH'(Overrun),  WIDTH'(e.overrun));
    endtask

    // Monitor: every cycle the DUT presents a fresh output word, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    task automatic strobe(input logic [WIDTH-1:0] d, input int lowCyc, input int highCyc,
                          input logic rdAtEnd = 1'b0);
        for (int i = 0; i < lowCyc; i++) applyStimulus(1'b0, 1'b0, d);
        for (int i = 0; i < highCyc; i++) applyStimulus(1'b0, 1'b1, d, (i == highCyc - 1) && rdAtEnd);
    endtask

    initial begin
        int hold;
        logic stbLvl;
        modelFlushHistory();

        applyStimulus(1'b1, 1'b1, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'h00);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 8'h00);

        // Basic capture, then an interrupt-enabled strobe and read.
        strobe(8'hA5, 4, 4, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1);
        strobe(8'h3C, 3, 4);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h00);

        // Overruns up to and past saturation.
        strobe(8'h11, 2, 3);
        strobe(8'h22, 2, 3);
        for (int i = 0; i < 15; i++) strobe(8'(8'h30 + i), 2, 3);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h00);

        // Read lands on the same edge as the fall-detect of a new strobe.
        strobe(8'h55, 2, 3);
        for (int i = 0; i < SYNC_STAGES; i++) applyStimulus(1'b0, 1'b0, 8'h77);
        applyStimulus(1'b0, 1'b0, 8'h77, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1);

        // Reset mid-handshake with strobe held low across release.
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 8'h99);
        applyStimulus(1'b1, 1'b0, 8'h99);
        applyStimulus(1'b1, 1'b0, 8'h99);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 8'h66);
        strobe(8'h44, 0, 3);
        strobe(8'h88, 3, 3, 1'b1);

        // Plain latched input mode.
        modeSel = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 8'h01);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 8'h02);
        strobe(8'h03, 2, 3);
        modeSel = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'h00);

        // Randomized traffic.
        stbLvl = 1'b1;
        hold = 3;
        for (int i = 0; i < 2000; i++) begin
            if (hold == 0) begin
                stbLvl = ~stbLvl;
                hold = $urandom_range(1, 5);
            end
            hold--;
            if ($urandom_range(0, 150) == 0) modeSel = ~modeSel;
            applyStimulus($urandom_range(0, 250) == 0, stbLvl, 8'($urandom),
                          $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                          1'($urandom));
        end
        modeSel = 1'b1;
        applyStimulus(1'b0, 1'b1, 8'h00);

        for (int i = 0; i < 20 && expQ.size() > 0; i++) @(posedge Clk);
        if (expQ.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain: %0d expected words left, required 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
